dev_bus_bridge: RTL

CPU-side initiator for the peripheral bus that our timer-class devices respond on. Takes one CPU load/store request at a time, decodes the address into a device select and word offset, and drives each device's ADD_I/WE_I/DAT_I. It returns the device's DAT_O to the CPU with a ready/error handshake. It also latches single-cycle device IRQ pulses into sticky hardware-interrupt lines for the CP0 HWInt inputs.

---
 rtl/dev_bus_bridge_pkg.sv | 31 +++
 rtl/dev_bus_bridge_if.sv | 44 ++++
 rtl/dev_bus_bridge_addr_dec.sv | 41 ++++
 rtl/dev_bus_bridge.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/dev_bus_bridge_pkg.sv
// ---------------------------------------------------------------------------
// bridge_pkg
//   Shared types and constants for the CPU-to-device bus bridge and for any
//   other initiator that reuses the window address decoder.
//   - state_t   : bridge FSM states
//   - dec_t     : address decode result
//   - IPEND_OFS : window offset of the interrupt-pending register
//   - DEV_STRIDE: bytes of address space per device (four 32-bit words)
//   - HWINT_W   : width of the CP0 hardware-interrupt vector
// ---------------------------------------------------------------------------
package bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [7:0] IPEND_OFS  = 8'hF0;
    localparam int         DEV_STRIDE = 16;
    localparam int         HWINT_W    = 6;

    typedef struct packed {
        logic       hit_dev;   // aligned access to an attached device
        logic [1:0] dev_idx;   // device number, valid with hit_dev
        logic       is_ipend;  // interrupt-pending register
        logic       err;       // neither of the above
        logic [1:0] offset;    // word offset inside the device
    } dec_t;

endpackage

// File: rtl/dev_bus_bridge_if.sv
// ---------------------------------------------------------------------------
// dev_bus_bridge_if
//   Bundles the CPU request/response handshake, the shared device bus and
//   the interrupt lines of the bridge.
//   CPU side   : cpu_req, cpu_we, cpu_addr, cpu_wdata -> bridge
//                cpu_rdata, cpu_ready, cpu_err        <- bridge
//   Device side: dev_add, dev_wdata, dev_we           <- bridge
//                dev_rdata (32 bits per device), dev_irq -> bridge
//   CP0 side   : hw_int                               <- bridge
//   modport master : the bridge (initiator on the device bus)
//   modport slave  : the environment (CPU plus attached devices)
// ---------------------------------------------------------------------------
interface dev_bus_bridge_if #(
    parameter int NUM_DEV = 2
);
    import bridge_pkg::*;

    logic                     cpu_req;
    logic                     cpu_we;
    logic [31:0]              cpu_addr;
    logic [31:0]              cpu_wdata;
    logic [31:0]              cpu_rdata;
    logic                     cpu_ready;
    logic                     cpu_err;

    logic [1:0]               dev_add;
    logic [31:0]              dev_wdata;
    logic [NUM_DEV-1:0]       dev_we;
    logic [32*NUM_DEV-1:0]    dev_rdata;
    logic [NUM_DEV-1:0]       dev_irq;

    logic [HWINT_W-1:0]       hw_int;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, dev_rdata, dev_irq,
        output cpu_rdata, cpu_ready, cpu_err, dev_add, dev_wdata, dev_we, hw_int
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, dev_rdata, dev_irq,
        input  cpu_rdata, cpu_ready, cpu_err, dev_add, dev_wdata, dev_we, hw_int
    );

endinterface

// File: rtl/dev_bus_bridge_addr_dec.sv
// ---------------------------------------------------------------------------
// bridge_addr_dec
//   Purely combinational decode of a CPU byte address against the device
//   window starting at BASE.
//   Ports:
//     addr : byte address to classify
//     dec  : {hit_dev, dev_idx, is_ipend, err, offset}
//   Device k owns BASE + k*DEV_STRIDE .. +DEV_STRIDE-1 (word aligned only);
//   BASE + IPEND_OFS is the pending register; every other address faults.
// ---------------------------------------------------------------------------
module bridge_addr_dec
    import bridge_pkg::*;
#(
    parameter logic [31:0] BASE    = 32'h0000_7F00,
    parameter int          NUM_DEV = 2
) (
    input  logic [31:0] addr,
    output dec_t        dec
);

    localparam int IDX_LSB = $clog2(DEV_STRIDE);

    logic        in_win;
    logic        aligned;
    logic [31:0] slot;

    always_comb begin
        in_win  = (addr[31:8] == BASE[31:8]);
        aligned = (addr[1:0] == 2'b00);
        slot    = 32'(addr[7:IDX_LSB]);

        dec.offset   = addr[3:2];
        dec.dev_idx  = addr[IDX_LSB+1:IDX_LSB];
        // IPEND sits in slot 15, which can never be a device (NUM_DEV <= 4),
        // so the two hits are mutually exclusive.
        dec.is_ipend = in_win && (addr[7:0] == IPEND_OFS);
        dec.hit_dev  = in_win && aligned && (slot < 32'(NUM_DEV));
        dec.err      = !(dec.hit_dev || dec.is_ipend);
    end

endmodule

// File: rtl/dev_bus_bridge.sv
// ---------------------------------------------------------------------------
// dev_bus_bridge
//   CPU-side initiator for the timer-class peripheral bus. Accepts one
//   load/store at a time, runs it as IDLE -> ACCESS -> RESP (3 cycles), and
//   collects single-cycle device IRQ pulses into sticky CP0 HWInt lines.
//   Ports:
//     CLK_I : clock, rising edge
//     RST_I : synchronous active-low reset
//     bus   : dev_bus_bridge_if.master (CPU handshake, device bus, hw_int)
//   The request is latched in IDLE; later changes on cpu_* are ignored until
//   the bridge returns to IDLE. dev_add/dev_wdata come straight from the
//   latched request, so they are stable for the whole ACCESS cycle.
// ---------------------------------------------------------------------------
module dev_bus_bridge
    import bridge_pkg::*;
#(
    parameter logic [31:0] BASE    = 32'h0000_7F00,
    parameter int          NUM_DEV = 2
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    dev_bus_bridge_if.master  bus
);

    state_t              state;
    state_t              state_nxt;

    dec_t                dec;
    dec_t                lat_dec;
    logic                lat_we;
    logic [31:0]         lat_wdata;

    logic [31:0]         rdata_q;
    logic [31:0]         rdata_sel;
    logic [HWINT_W-1:0]  pending;
    logic [HWINT_W-1:0]  irq_set;
    logic [HWINT_W-1:0]  ipend_clr;

    logic [NUM_DEV-1:0]  we_vec;
    logic                ready;
    logic                err;

    bridge_addr_dec #(
        .BASE    (BASE),
        .NUM_DEV (NUM_DEV)
    ) u_addr_dec (
        .addr (bus.cpu_addr),
        .dec  (dec)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK_I) begin
        if (!RST_I) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (bus.cpu_req) state_nxt = ST_ACCESS;
            ST_ACCESS: state_nxt = ST_RESP;
            ST_RESP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        we_vec = '0;
        ready  = 1'b0;
        err    = 1'b0;
        case (state)
            ST_ACCESS: begin
                if (lat_we && lat_dec.hit_dev) begin
                    for (int k = 0; k < NUM_DEV; k++) begin
                        if (lat_dec.dev_idx == 2'(k)) we_vec[k] = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                ready = 1'b1;
                err   = lat_dec.err;
            end
            default: ;
        endcase
    end

    // ---------------- read data / interrupt vectors ----------------
    always_comb begin
        rdata_sel = '0;
        if (lat_dec.hit_dev) begin
            for (int k = 0; k < NUM_DEV; k++) begin
                if (lat_dec.dev_idx == 2'(k)) rdata_sel = bus.dev_rdata[32*k +: 32];
            end
        end else if (lat_dec.is_ipend) begin
            rdata_sel = 32'(pending);
        end
    end

    // Only implemented bits can be set or cleared; the upper hw_int lines
    // therefore stay at zero.
    always_comb begin
        irq_set                = '0;
        irq_set[NUM_DEV-1:0]   = bus.dev_irq;
        ipend_clr              = '0;
        if (state == ST_ACCESS && lat_we && lat_dec.is_ipend)
            ipend_clr[NUM_DEV-1:0] = lat_wdata[NUM_DEV-1:0];
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            lat_we    <= 1'b0;
            lat_wdata <= '0;
            lat_dec   <= '0;
            rdata_q   <= '0;
            pending   <= '0;
        end else begin
            if (state == ST_IDLE && bus.cpu_req) begin
                lat_we    <= bus.cpu_we;
                lat_wdata <= bus.cpu_wdata;
                lat_dec   <= dec;
            end
            // Loads capture their data; a faulting access of either
            // direction returns zero (rdata_sel is zero on a fault).
            // Good stores leave the previous value in place.
            if (state == ST_ACCESS && (!lat_we || lat_dec.err))
                rdata_q <= rdata_sel;
            // Set has priority over a same-cycle write-1-to-clear.
            pending <= (pending & ~ipend_clr) | irq_set;
        end
    end

    assign bus.cpu_rdata = rdata_q;
    assign bus.cpu_ready = ready;
    assign bus.cpu_err   = err;
    assign bus.dev_add   = lat_dec.offset;
    assign bus.dev_wdata = lat_wdata;
    assign bus.dev_we    = we_vec;
    assign bus.hw_int    = pending;

endmodule
